// File: rtl/mmu_sfr_read_unit_if.sv
// Bus bundle for the SFR read unit: one write port plus NUM_RD pipelined read channels.
interface mmu_sfr_read_unit_if #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8,
  parameter int NUM_RD = 2
);
  logic                     wr_en_i;
  logic [IDX_W-1:0]         wr_idx_i;
  logic [DATA_W-1:0]        wr_data_i;
  logic                     wr_err_o;
  logic [NUM_RD-1:0]        rd_en_i;
  logic [NUM_RD*IDX_W-1:0]  rd_idx_i;
  logic                     stall_i;
  logic [NUM_RD*DATA_W-1:0] rd_result_o;
  logic [NUM_RD-1:0]        rd_valid_o;
  logic [NUM_RD-1:0]        rd_err_o;

  modport master (
    output wr_en_i, wr_idx_i, wr_data_i, rd_en_i, rd_idx_i, stall_i,
    input  wr_err_o, rd_result_o, rd_valid_o, rd_err_o
  );

  modport slave (
    input  wr_en_i, wr_idx_i, wr_data_i, rd_en_i, rd_idx_i, stall_i,
    output wr_err_o, rd_result_o, rd_valid_o, rd_err_o
  );
endinterface

// File: rtl/mmu_sfr_read_unit.sv
// Multi-port SFR file between decode and register-read: one write port with write-first
// bypass, NUM_RD stall-aware read channels, per-register read-to-clear, range error flags.
module mmu_sfr_read_unit #(
  parameter int                 DATA_W  = 32,
  parameter int                 IDX_W   = 8,
  parameter int                 NUM_SFR = 64,
  parameter int                 NUM_RD  = 2,
  parameter logic [NUM_SFR-1:0] RC_MASK = '0
) (
  input logic                clock,
  input logic                reset,
  mmu_sfr_read_unit_if.slave bus
);

  localparam logic [IDX_W:0] NUM_SFR_W = (IDX_W + 1)'(NUM_SFR);

  logic [NUM_SFR-1:0][DATA_W-1:0] sfr_r;
  logic [NUM_RD-1:0][DATA_W-1:0]  result_r;
  logic [NUM_RD-1:0]              valid_r;
  logic [NUM_RD-1:0]              err_r;
  logic                           wr_err_r;

  logic [NUM_RD-1:0][IDX_W-1:0]   rd_idx_s;
  logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_s;
  logic [NUM_RD-1:0]              accept_s;
  logic [NUM_RD-1:0]              in_range_s;
  logic [NUM_SFR-1:0]             clr_s;
  logic                           wr_ok_s;
  logic                           wr_bad_s;

  assign rd_idx_s = bus.rd_idx_i;

  // Write qualification: out-of-range writes are dropped and flagged.
  always_comb begin
    wr_ok_s  = 1'b0;
    wr_bad_s = 1'b0;
    if (bus.wr_en_i) begin
      wr_ok_s  = ({1'b0, bus.wr_idx_i} < NUM_SFR_W);
      wr_bad_s = ~wr_ok_s;
    end else begin
      wr_ok_s  = 1'b0;
      wr_bad_s = 1'b0;
    end
  end

  // Per-channel read mux; a same-cycle in-range write to the same index wins (write-first).
  always_comb begin
    for (int c = 0; c < NUM_RD; c++) begin
      accept_s[c]   = bus.rd_en_i[c] & ~bus.stall_i;
      in_range_s[c] = ({1'b0, rd_idx_s[c]} < NUM_SFR_W);
      rd_data_s[c]  = '0;
      if (wr_ok_s && (bus.wr_idx_i == rd_idx_s[c])) begin
        rd_data_s[c] = bus.wr_data_i;
      end else begin
        for (int k = 0; k < NUM_SFR; k++) begin
          rd_data_s[c] = rd_data_s[c] |
                         ((rd_idx_s[c] == IDX_W'(k)) ? sfr_r[k] : {DATA_W{1'b0}});
        end
      end
    end
  end

  // Read-to-clear requests; several channels hitting the same SFR collapse into one clear.
  always_comb begin
    clr_s = '0;
    for (int k = 0; k < NUM_SFR; k++) begin
      for (int c = 0; c < NUM_RD; c++) begin
        clr_s[k] = clr_s[k] | (RC_MASK[k] & accept_s[c] & (rd_idx_s[c] == IDX_W'(k)));
      end
    end
  end

  // SFR storage: write beats read-to-clear on the same register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sfr_r <= '0;
    end else begin
      for (int k = 0; k < NUM_SFR; k++) begin
        if (wr_ok_s && (bus.wr_idx_i == IDX_W'(k))) begin
          sfr_r[k] <= bus.wr_data_i;
        end else if (clr_s[k]) begin
          sfr_r[k] <= '0;
        end else begin
          sfr_r[k] <= sfr_r[k];
        end
      end
    end
  end

  // Read result pipeline; stall freezes every read-side register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_r <= '0;
      valid_r  <= '0;
      err_r    <= '0;
    end else if (!bus.stall_i) begin
      for (int c = 0; c < NUM_RD; c++) begin
        if (accept_s[c]) begin
          result_r[c] <= in_range_s[c] ? rd_data_s[c] : {DATA_W{1'b0}};
          valid_r[c]  <= 1'b1;
          err_r[c]    <= ~in_range_s[c];
        end else begin
          result_r[c] <= result_r[c];
          valid_r[c]  <= 1'b0;
          err_r[c]    <= 1'b0;
        end
      end
    end else begin
      result_r <= result_r;
      valid_r  <= valid_r;
      err_r    <= err_r;
    end
  end

  // Dropped-write flag, one cycle per offending write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_err_r <= 1'b0;
    end else begin
      wr_err_r <= wr_bad_s;
    end
  end

  assign bus.rd_result_o = result_r;
  assign bus.rd_valid_o  = valid_r;
  assign bus.rd_err_o    = err_r;
  assign bus.wr_err_o    = wr_err_r;

endmodule

// File: tb/tb_mmu_sfr_read_unit.sv
// Directed, table-driven bench for mmu_sfr_read_unit (64 SFRs, 2 channels, SFR3 read-to-clear).
module tb_mmu_sfr_read_unit;

  localparam int DATA_W = 32;
  localparam int IDX_W  = 8;
  localparam int NUM_RD = 2;
  localparam int NVEC   = 22;

  typedef struct packed {
    logic        wr_en;
    logic [7:0]  wr_idx;
    logic [31:0] wr_data;
    logic        stall;
    logic [1:0]  rd_en;
    logic [7:0]  idx0;
    logic [7:0]  idx1;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic [1:0]  exp_valid;
    logic [1:0]  exp_err;
    logic        exp_wr_err;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  vec_t vecs [NVEC];

  mmu_sfr_read_unit_if #(.DATA_W(DATA_W), .IDX_W(IDX_W), .NUM_RD(NUM_RD)) bus ();

  mmu_sfr_read_unit #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .NUM_SFR(64),
    .NUM_RD (NUM_RD),
    .RC_MASK(64'h0000_0000_0000_0008)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(input logic we, input logic [7:0] wi, input logic [31:0] wd,
                              input logic st, input logic [1:0] re, input logic [7:0] i0,
                              input logic [7:0] i1, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [1:0] ev, input logic [1:0] ee, input logic ew);
    vec_t v;
    v = '{we, wi, wd, st, re, i0, i1, e0, e1, ev, ee, ew};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [1:0] ev, input logic [1:0] ee, input logic ew);
    check({tag, ".result0"}, bus.rd_result_o[31:0], e0);
    check({tag, ".result1"}, bus.rd_result_o[63:32], e1);
    check({tag, ".valid"}, {30'd0, bus.rd_valid_o}, {30'd0, ev});
    check({tag, ".err"}, {30'd0, bus.rd_err_o}, {30'd0, ee});
    check({tag, ".wr_err"}, {31'd0, bus.wr_err_o}, {31'd0, ew});
  endtask

  task automatic drive(input vec_t v);
    bus.wr_en_i   = v.wr_en;
    bus.wr_idx_i  = v.wr_idx;
    bus.wr_data_i = v.wr_data;
    bus.stall_i   = v.stall;
    bus.rd_en_i   = v.rd_en;
    bus.rd_idx_i  = {v.idx1, v.idx0};
  endtask

  task automatic idle();
    drive(mk(1'b0, 8'd0, 32'd0, 1'b0, 2'b00, 8'd0, 8'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    //            we    widx    wdata          st    ren    i0      i1      exp0           exp1           ev     ee     ew
    vecs[0]  = mk(1'b1, 8'd5,   32'hDEADBEEF, 1'b0, 2'b00, 8'd0,   8'd0,   32'h0,         32'h0,         2'b00, 2'b00, 1'b0);
    vecs[1]  = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b01, 8'd5,   8'd0,   32'hDEADBEEF, 32'h0,         2'b01, 2'b00, 1'b0);
    vecs[2]  = mk(1'b0, 8'd0,   32'h0,        1'b1, 2'b11, 8'd5,   8'd5,   32'hDEADBEEF, 32'h0,         2'b01, 2'b00, 1'b0);
    vecs[3]  = mk(1'b0, 8'd0,   32'h0,        1'b1, 2'b11, 8'd5,   8'd5,   32'hDEADBEEF, 32'h0,         2'b01, 2'b00, 1'b0);
    vecs[4]  = mk(1'b0, 8'd0,   32'h0,        1'b1, 2'b11, 8'd5,   8'd5,   32'hDEADBEEF, 32'h0,         2'b01, 2'b00, 1'b0);
    vecs[5]  = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b11, 8'd5,   8'd5,   32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 2'b00, 1'b0);
    vecs[6]  = mk(1'b1, 8'd9,   32'h12345678, 1'b0, 2'b10, 8'd0,   8'd9,   32'hDEADBEEF, 32'h12345678, 2'b10, 2'b00, 1'b0);
    vecs[7]  = mk(1'b1, 8'd3,   32'h000000A5, 1'b0, 2'b00, 8'd0,   8'd0,   32'hDEADBEEF, 32'h12345678, 2'b00, 2'b00, 1'b0);
    vecs[8]  = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b01, 8'd3,   8'd0,   32'h000000A5, 32'h12345678, 2'b01, 2'b00, 1'b0);
    vecs[9]  = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b01, 8'd3,   8'd0,   32'h0,         32'h12345678, 2'b01, 2'b00, 1'b0);
    vecs[10] = mk(1'b1, 8'd3,   32'h00000077, 1'b0, 2'b11, 8'd3,   8'd3,   32'h00000077, 32'h00000077, 2'b11, 2'b00, 1'b0);
    vecs[11] = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b01, 8'd3,   8'd0,   32'h00000077, 32'h00000077, 2'b01, 2'b00, 1'b0);
    vecs[12] = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b10, 8'd0,   8'd3,   32'h00000077, 32'h0,         2'b10, 2'b00, 1'b0);
    vecs[13] = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b01, 8'd64,  8'd0,   32'h0,         32'h0,         2'b01, 2'b01, 1'b0);
    vecs[14] = mk(1'b1, 8'd200, 32'hFFFFFFFF, 1'b0, 2'b10, 8'd0,   8'd255, 32'h0,         32'h0,         2'b10, 2'b10, 1'b1);
    vecs[15] = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b00, 8'd0,   8'd0,   32'h0,         32'h0,         2'b00, 2'b00, 1'b0);
    vecs[16] = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b11, 8'd9,   8'd5,   32'h12345678, 32'hDEADBEEF, 2'b11, 2'b00, 1'b0);
    vecs[17] = mk(1'b1, 8'd9,   32'hCAFEF00D, 1'b1, 2'b11, 8'd9,   8'd9,   32'h12345678, 32'hDEADBEEF, 2'b11, 2'b00, 1'b0);
    vecs[18] = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b11, 8'd9,   8'd63,  32'hCAFEF00D, 32'h0,         2'b11, 2'b00, 1'b0);
    vecs[19] = mk(1'b1, 8'd3,   32'h00000011, 1'b0, 2'b00, 8'd0,   8'd0,   32'hCAFEF00D, 32'h0,         2'b00, 2'b00, 1'b0);
    vecs[20] = mk(1'b0, 8'd0,   32'h0,        1'b1, 2'b01, 8'd3,   8'd0,   32'hCAFEF00D, 32'h0,         2'b00, 2'b00, 1'b0);
    vecs[21] = mk(1'b0, 8'd0,   32'h0,        1'b0, 2'b01, 8'd3,   8'd0,   32'h00000011, 32'h0,         2'b01, 2'b00, 1'b0);

    reset = 1'b0;
    idle();
    #12;
    check_outputs("reset", 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clock);
      drive(vecs[i]);
      @(posedge clock);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp0, vecs[i].exp1,
                    vecs[i].exp_valid, vecs[i].exp_err, vecs[i].exp_wr_err);
    end

    // Asynchronous reset with both channels valid, then SFRs read back as zero.
    @(negedge clock);
    drive(mk(1'b0, 8'd0, 32'h0, 1'b0, 2'b11, 8'd9, 8'd5, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0));
    @(posedge clock);
    #1;
    check_outputs("pre_rst", 32'hCAFEF00D, 32'hDEADBEEF, 2'b11, 2'b00, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_outputs("async_rst", 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    idle();
    @(negedge clock);
    drive(mk(1'b0, 8'd0, 32'h0, 1'b0, 2'b11, 8'd9, 8'd5, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0));
    @(posedge clock);
    #1;
    check_outputs("post_rst", 32'h0, 32'h0, 2'b11, 2'b00, 1'b0);
    @(negedge clock);
    idle();
    @(posedge clock);
    #1;
    check_outputs("post_rst_idle", 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
